key_conditioner_module: RTL

Parametrised N-channel front end for the push-button inputs of the game. It replaces the four separate single-key debouncers with one block. Per channel it provides:
- a 2-FF synchroniser
- a stable-level debouncer
- one-cycle press/release strobes
- optional auto-repeat (hold-to-move for left/right/down)

It sits between the board buttons and the game control logic, clocked by the 25 MHz pixel clock.

---
 rtl/key_conditioner_module.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/key_conditioner_module.sv
// rtl/key_conditioner_module.sv - N-channel push-button synchroniser, debouncer, strobe and auto-repeat front end
module key_conditioner_module #(
    parameter int                N_KEYS          = 4,
    parameter int                ACTIVE_LOW      = 1,
    parameter int                DEBOUNCE_CYCLES = 250000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = 4'b1011,
    parameter int                REPEAT_DELAY    = 5000000,
    parameter int                REPEAT_PERIOD   = 2500000,
    parameter int                CNT_W           = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    input  logic              enable,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              any_press
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        DELAY  = 2'd2,
        REPEAT = 2'd3
    } key_state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // Raw inputs normalised so that 1 always means pressed.
    logic [N_KEYS-1:0] raw_pressed;
    assign raw_pressed = (ACTIVE_LOW != 0) ? ~key_in : key_in;

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] level_q;
    logic [CNT_W-1:0]  db_cnt_q [N_KEYS];
    logic [N_KEYS-1:0] rise;
    logic [N_KEYS-1:0] fall;

    key_state_t        state_q   [N_KEYS];
    key_state_t        state_d   [N_KEYS];
    logic [CNT_W-1:0]  rpt_cnt_q [N_KEYS];
    logic [CNT_W-1:0]  rpt_cnt_d [N_KEYS];
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] release_q;
    logic [N_KEYS-1:0] release_d;

    // Two-stage synchroniser; reset loads the released level so no phantom press follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_pressed;
            sync2_q <= sync1_q;
        end
    end

    // Accepted level changes: the synchronised level has disagreed for DEBOUNCE_CYCLES edges.
    always_comb begin
        rise = '0;
        fall = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if ((sync2_q[i] != level_q[i]) && (db_cnt_q[i] == DB_LAST)) begin
                rise[i] = sync2_q[i];
                fall[i] = ~sync2_q[i];
            end
        end
    end

    // Debounce counters and the debounced level; any agreeing cycle restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= CNT_ZERO;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_cnt_q[i] <= CNT_ZERO;
                    level_q[i]  <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Per-channel state register, repeat counters and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i]   <= IDLE;
                rpt_cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i]   <= state_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    // Next-state and strobe decode; a release always beats a repeat due on the same edge.
    always_comb begin
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i]   = state_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    rpt_cnt_d[i] = CNT_ZERO;
                    if (rise[i]) begin
                        press_d[i] = 1'b1;
                        state_d[i] = REPEAT_MASK[i] ? DELAY : HELD;
                    end
                end
                HELD: begin
                    if (fall[i]) begin
                        release_d[i] = 1'b1;
                        state_d[i]   = IDLE;
                    end
                end
                DELAY: begin
                    if (fall[i]) begin
                        release_d[i] = 1'b1;
                        state_d[i]   = IDLE;
                        rpt_cnt_d[i] = CNT_ZERO;
                    end else if (rpt_cnt_q[i] == RD_LAST) begin
                        press_d[i]   = 1'b1;
                        state_d[i]   = REPEAT;
                        rpt_cnt_d[i] = CNT_ZERO;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (fall[i]) begin
                        release_d[i] = 1'b1;
                        state_d[i]   = IDLE;
                        rpt_cnt_d[i] = CNT_ZERO;
                    end else if (rpt_cnt_q[i] == RP_LAST) begin
                        press_d[i]   = 1'b1;
                        rpt_cnt_d[i] = CNT_ZERO;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i]   = IDLE;
                    rpt_cnt_d[i] = CNT_ZERO;
                end
            endcase
        end
    end

    // enable only masks what leaves the block; timing inside keeps running.
    assign key_level   = level_q;
    assign key_press   = press_q & {N_KEYS{enable}};
    assign key_release = release_q & {N_KEYS{enable}};
    assign any_press   = |key_press;

endmodule
